// File: rtl/adder_share_arbiter.sv
// Purpose : round-robin share of one external combinational adder between two requesters,
//           with a registered sum/carry response slot per requester.
// Latency : result visible 1 cycle after the req handshake; backpressure: a full, unaccepted slot blocks its requester.
// Ports   : clk/rst_n; reqN_valid/a/b/ready (operand handshake); rspN_valid/sum/carry/ready (result handshake);
//           add_in_1/add_in_2 -> shared adder, add_sum <- shared adder; contention_cnt (saturating).
module adder_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_sum,
  output logic             rsp0_carry,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_sum,
  output logic             rsp1_carry,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] add_in_1,
  output logic [WIDTH-1:0] add_in_2,
  input  logic [WIDTH-1:0] add_sum,
  output logic [CNT_W-1:0] contention_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic ptr;          // 0: req0 wins a tie, 1: req1 wins a tie
  logic slot_free0, slot_free1;
  logic elig0, elig1;
  logic grant0, grant1;
  logic carry;

  // A slot being drained this cycle can accept a new result in the same cycle.
  assign slot_free0 = !rsp0_valid || rsp0_ready;
  assign slot_free1 = !rsp1_valid || rsp1_ready;
  assign elig0      = req0_valid && slot_free0;
  assign elig1      = req1_valid && slot_free1;

  // Grants are forced low while reset is held so no handshake is seen during reset.
  assign grant0 = rst_n && elig0 && (!elig1 || !ptr);
  assign grant1 = rst_n && elig1 && (!elig0 ||  ptr);

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Idle cycles steer req0 operands so the adder inputs are never undefined.
  assign add_in_1 = grant1 ? req1_a : req0_a;
  assign add_in_2 = grant1 ? req1_b : req0_b;

  // Unsigned wrap detection: a modular sum smaller than one operand means a carry out.
  assign carry = (add_sum < add_in_1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid <= 1'b0;
      rsp0_sum   <= '0;
      rsp0_carry <= 1'b0;
    end else if (grant0) begin
      rsp0_valid <= 1'b1;
      rsp0_sum   <= add_sum;
      rsp0_carry <= carry;
    end else if (rsp0_ready) begin
      rsp0_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp1_valid <= 1'b0;
      rsp1_sum   <= '0;
      rsp1_carry <= 1'b0;
    end else if (grant1) begin
      rsp1_valid <= 1'b1;
      rsp1_sum   <= add_sum;
      rsp1_carry <= carry;
    end else if (rsp1_ready) begin
      rsp1_valid <= 1'b0;
    end
  end

  // After a grant the other requester gets the next tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (grant0) begin
      ptr <= 1'b1;
    end else if (grant1) begin
      ptr <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      contention_cnt <= '0;
    end else if (elig0 && elig1 && (contention_cnt != CNT_MAX)) begin
      contention_cnt <= contention_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Purpose : directed, table-driven check of adder_share_arbiter with a behavioural shared adder.
// Latency : each vector is one clock; combinational outputs checked mid-cycle, registered ones 1 time unit after the edge.
// Backpressure: rsp ready inputs are driven per vector to exercise slot hold/drain.
module tb_adder_share_arbiter;

  localparam int WIDTH = 32;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic             req0_ready, req1_ready;
  logic             rsp0_valid, rsp1_valid, rsp0_carry, rsp1_carry;
  logic [WIDTH-1:0] rsp0_sum, rsp1_sum;
  logic             rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [WIDTH-1:0] add_in_1, add_in_2, add_sum;
  logic [CNT_W-1:0] contention_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Behavioural model of the shared combinational adder.
  assign add_sum = add_in_1 + add_in_2;

  adder_share_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_sum(rsp0_sum), .rsp0_carry(rsp0_carry), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_sum(rsp1_sum), .rsp1_carry(rsp1_carry), .rsp1_ready(rsp1_ready),
    .add_in_1(add_in_1), .add_in_2(add_in_2), .add_sum(add_sum),
    .contention_cnt(contention_cnt)
  );

  typedef struct {
    logic        r0v;
    logic [31:0] r0a, r0b;
    logic        r1v;
    logic [31:0] r1a, r1b;
    logic        k0, k1;
    logic        g0, g1;
    logic [31:0] ai1;
    logic        v0;
    logic [31:0] s0;
    logic        c0;
    logic        v1;
    logic [31:0] s1;
    logic        c1;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive(input logic r0v, input logic [31:0] r0a, input logic [31:0] r0b,
                       input logic r1v, input logic [31:0] r1a, input logic [31:0] r1b,
                       input logic k0, input logic k1);
    req0_valid = r0v; req0_a = r0a; req0_b = r0b;
    req1_valid = r1v; req1_a = r1a; req1_b = r1b;
    rsp0_ready = k0;  rsp1_ready = k1;
  endtask

  initial begin
    // Contention phase operands: req0 12345678+11111111, req1 80000000+80000001, then fresh pairs after each handshake.
    tbl[0]  = '{1'b1, 32'h00000004, 32'h00001000, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1,
                1'b1, 1'b0, 32'h00000004, 1'b1, 32'h00001004, 1'b0, 1'b0, 32'h0, 1'b0, 16'd0};
    tbl[1]  = '{1'b0, 32'h0, 32'h0, 1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b1,
                1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h00001004, 1'b0, 1'b1, 32'h00000000, 1'b1, 16'd0};
    tbl[2]  = '{1'b1, 32'h12345678, 32'h11111111, 1'b1, 32'h80000000, 32'h80000001, 1'b1, 1'b1,
                1'b1, 1'b0, 32'h12345678, 1'b1, 32'h23456789, 1'b0, 1'b0, 32'h00000000, 1'b1, 16'd1};
    tbl[3]  = '{1'b1, 32'hF0000000, 32'h20000000, 1'b1, 32'h80000000, 32'h80000001, 1'b1, 1'b1,
                1'b0, 1'b1, 32'h80000000, 1'b0, 32'h23456789, 1'b0, 1'b1, 32'h00000001, 1'b1, 16'd2};
    tbl[4]  = '{1'b1, 32'hF0000000, 32'h20000000, 1'b1, 32'h00000010, 32'h00000020, 1'b1, 1'b1,
                1'b1, 1'b0, 32'hF0000000, 1'b1, 32'h10000000, 1'b1, 1'b0, 32'h00000001, 1'b1, 16'd3};
    tbl[5]  = '{1'b1, 32'h7FFFFFFF, 32'h00000001, 1'b1, 32'h00000010, 32'h00000020, 1'b1, 1'b1,
                1'b0, 1'b1, 32'h00000010, 1'b0, 32'h10000000, 1'b1, 1'b1, 32'h00000030, 1'b0, 16'd4};
    tbl[6]  = '{1'b1, 32'h7FFFFFFF, 32'h00000001, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1,
                1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 32'h80000000, 1'b0, 1'b0, 32'h00000030, 1'b0, 16'd5};
    tbl[7]  = '{1'b1, 32'h00000001, 32'h00000002, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1,
                1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b1, 16'd6};
    // Backpressure on slot 0 while req1 keeps being served.
    tbl[8]  = '{1'b1, 32'h00000001, 32'h00000002, 1'b1, 32'h00000100, 32'h00000200, 1'b0, 1'b1,
                1'b1, 1'b0, 32'h00000001, 1'b1, 32'h00000003, 1'b0, 1'b0, 32'hFFFFFFFE, 1'b1, 16'd7};
    tbl[9]  = '{1'b1, 32'h00000005, 32'h00000006, 1'b1, 32'h00000100, 32'h00000200, 1'b0, 1'b1,
                1'b0, 1'b1, 32'h00000100, 1'b1, 32'h00000003, 1'b0, 1'b1, 32'h00000300, 1'b0, 16'd7};
    tbl[10] = '{1'b1, 32'h00000005, 32'h00000006, 1'b1, 32'h00001000, 32'h00000001, 1'b0, 1'b1,
                1'b0, 1'b1, 32'h00001000, 1'b1, 32'h00000003, 1'b0, 1'b1, 32'h00001001, 1'b0, 16'd7};
    tbl[11] = '{1'b1, 32'h00000005, 32'h00000006, 1'b1, 32'h00000002, 32'h00000003, 1'b1, 1'b1,
                1'b1, 1'b0, 32'h00000005, 1'b1, 32'h0000000B, 1'b0, 1'b0, 32'h00001001, 1'b0, 16'd8};
    // Idle: adder inputs fall back to req0 operands.
    tbl[12] = '{1'b0, 32'hAAAA0000, 32'h00005555, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1,
                1'b0, 1'b0, 32'hAAAA0000, 1'b0, 32'h0000000B, 1'b0, 1'b0, 32'h00001001, 1'b0, 16'd8};

    // Reset held with both requesters valid.
    drive(1'b1, 32'h00000004, 32'h00001000, 1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst req0_ready", {31'b0, req0_ready}, 32'd0);
    chk("rst req1_ready", {31'b0, req1_ready}, 32'd0);
    chk("rst rsp0_valid", {31'b0, rsp0_valid}, 32'd0);
    chk("rst rsp1_valid", {31'b0, rsp1_valid}, 32'd0);
    chk("rst rsp0_sum", rsp0_sum, 32'd0);
    chk("rst contention_cnt", {16'b0, contention_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post-rst req0_ready", {31'b0, req0_ready}, 32'd1);
    chk("post-rst req1_ready", {31'b0, req1_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("post-rst rsp0_sum", rsp0_sum, 32'h00001004);

    // Table-driven sequence from a clean reset.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      if (i != 0) @(negedge clk);
      drive(tbl[i].r0v, tbl[i].r0a, tbl[i].r0b, tbl[i].r1v, tbl[i].r1a, tbl[i].r1b, tbl[i].k0, tbl[i].k1);
      #1;
      chk($sformatf("v%0d req0_ready", i), {31'b0, req0_ready}, {31'b0, tbl[i].g0});
      chk($sformatf("v%0d req1_ready", i), {31'b0, req1_ready}, {31'b0, tbl[i].g1});
      chk($sformatf("v%0d add_in_1", i), add_in_1, tbl[i].ai1);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d rsp0_valid", i), {31'b0, rsp0_valid}, {31'b0, tbl[i].v0});
      chk($sformatf("v%0d rsp0_sum", i), rsp0_sum, tbl[i].s0);
      chk($sformatf("v%0d rsp0_carry", i), {31'b0, rsp0_carry}, {31'b0, tbl[i].c0});
      chk($sformatf("v%0d rsp1_valid", i), {31'b0, rsp1_valid}, {31'b0, tbl[i].v1});
      chk($sformatf("v%0d rsp1_sum", i), rsp1_sum, tbl[i].s1);
      chk($sformatf("v%0d rsp1_carry", i), {31'b0, rsp1_carry}, {31'b0, tbl[i].c1});
      chk($sformatf("v%0d contention_cnt", i), {16'b0, contention_cnt}, {16'b0, tbl[i].cnt});
    end

    // Mid-stream reset: slot 1 full and stalled, pointer left favouring req1.
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h00000009, 32'h00000001, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b1, 32'h00000001, 32'h00000001, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("pre-arst rsp1_valid", {31'b0, rsp1_valid}, 32'd1);
    chk("pre-arst rsp1_sum", rsp1_sum, 32'h0000000A);
    @(negedge clk);
    drive(1'b1, 32'h00000001, 32'h00000001, 1'b1, 32'h00000007, 32'h00000007, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst rsp1_valid", {31'b0, rsp1_valid}, 32'd0);
    chk("arst rsp1_sum", rsp1_sum, 32'd0);
    chk("arst rsp0_valid", {31'b0, rsp0_valid}, 32'd0);
    chk("arst req0_ready", {31'b0, req0_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arst bias req0_ready", {31'b0, req0_ready}, 32'd1);
    chk("arst bias req1_ready", {31'b0, req1_ready}, 32'd0);

    // Saturation of the contention counter.
    do_reset();
    drive(1'b1, 32'h1, 32'h1, 1'b1, 32'h2, 32'h2, 1'b1, 1'b1);
    repeat (65534) @(posedge clk);
    #1;
    chk("cnt 65534", {16'b0, contention_cnt}, 32'd65534);
    repeat (6) @(posedge clk);
    #1;
    chk("cnt saturated", {16'b0, contention_cnt}, 32'd65535);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one combinational 32-bit Adder instance between two requesters, e.g. PC+4 increment (req0) and branch/jump target computation (req1) in the writeback/next-PC path.
- Each requester presents an operand pair over a valid/ready handshake. The arbiter grants one requester per cycle, round-robin, and drives the shared Adder's inputs.
- It registers the sum plus an unsigned carry flag into a per-requester response slot, held until the requester accepts it.

Parameters:
- WIDTH, 32, operand/sum width in bits.
- CNT_W, 16, width of the saturating contention counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has an operand pair.
- req0_a  input  WIDTH  requester 0 operand A.
- req0_b  input  WIDTH  requester 0 operand B.
- req0_ready  output  1  requester 0 granted this cycle.
- req1_valid  input  1  requester 1 has an operand pair.
- req1_a  input  WIDTH  requester 1 operand A.
- req1_b  input  WIDTH  requester 1 operand B.
- req1_ready  output  1  requester 1 granted this cycle.
- rsp0_valid  output  1  response slot 0 holds a result.
- rsp0_sum  output  WIDTH  registered sum for requester 0.
- rsp0_carry  output  1  unsigned carry-out for requester 0.
- rsp0_ready  input  1  requester 0 accepts its response.
- rsp1_valid, rsp1_sum, rsp1_carry, rsp1_ready: same as slot 0, for requester 1.
- add_in_1  output  WIDTH  to shared Adder in_1.
- add_in_2  output  WIDTH  to shared Adder in_2.
- add_sum  input  WIDTH  from shared Adder Sum_out.
- contention_cnt  output  CNT_W  cycles in which both requests were eligible.

Behaviour:
- Reset (rst_n low, asynchronous): rsp0_valid=rsp1_valid=0, rsp*_sum=0, rsp*_carry=0, contention_cnt=0, priority pointer=0 (req0 favoured). req*_ready=0 while rst_n is low.
- Slot free (per requester i): slot_free_i = !rspi_valid || rspi_ready. A response consumed in a cycle lets a new grant land in that same cycle; full throughput is 1 result per requester per cycle.
- Eligibility: eligible_i = reqi_valid && slot_free_i.
- Grant, combinational:
  - only one requester eligible: grant it.
  - both eligible: grant the one the pointer favours.
  - none eligible: no grant.
  - reqi_ready = grant_i. At most one reqi_ready is high per cycle.
- Adder drive: add_in_1/add_in_2 = granted requester's a/b. With no grant they carry req0_a/req0_b (don't-care functionally; fixed to avoid toggling ambiguity in sim).
- Capture: on the rising edge with grant_i, rspi_sum <= add_sum, rspi_carry <= (add_sum < add_in_1) unsigned, rspi_valid <= 1.
- Latency: the result is visible exactly 1 cycle after the handshake cycle.
- Hold: if rspi_valid && !rspi_ready && no new grant_i, slot i holds sum/carry/valid unchanged.
- Drain: if rspi_ready && !grant_i, rspi_valid <= 0. Sum/carry keep their last values.
- Pointer update: after any grant, the pointer moves to favour the other requester. Otherwise it is unchanged. There is no starvation: with both continuously eligible, grants alternate 0,1,0,1.
- Contention counter: increments by 1 on each cycle where eligible_0 && eligible_1. Saturates at 2^CNT_W-1, with no wrap.
- Arithmetic: sum is modulo 2^WIDTH. Carry is 1 exactly when the true sum is ≥ 2^WIDTH.
- Mid-operation reset: asserting rst_n low discards all held responses immediately, with no partial capture. After deassertion, arbitration restarts with the req0 bias.
- A requester must hold a/b stable while valid && !ready. Dropping valid without a handshake is legal; the arbiter keeps no memory of it.

Test Plan:
- Reset check: hold rst_n=0 with both valid -> all rsp*_valid=0, req*_ready=0, contention_cnt=0. Release -> req0 granted first.
- Single requester, req0 a=0x00000004, b=0x00001000, rsp0_ready=1 -> req0_ready=1 in cycle N. In cycle N+1: rsp0_valid=1, rsp0_sum=0x00001004, rsp0_carry=0.
- Overflow: req1 a=0xFFFFFFFF, b=0x00000001 -> rsp1_sum=0x00000000, rsp1_carry=1, and add_in_1=0xFFFFFFFF during the grant cycle.
- Contention: both valid continuously for 6 cycles, both rsp_ready=1 -> grant order 0,1,0,1,0,1; contention_cnt=6; each slot gets the correct sums (e.g. 0x12345678+0x11111111=0x23456789).
- Backpressure: rsp0_ready=0 after slot 0 fills, req0 still valid -> req0_ready stays 0 and slot 0 holds its value. req1 is still served every cycle. Raising rsp0_ready=1 -> req0 is granted that same cycle.
- Reset mid-stream: pull rst_n low while rsp1_valid=1 -> rsp1_valid drops to 0 immediately, asynchronously, before the next clock edge.
